// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: steps through a DEPTH-entry table of WIDTH-bit codes, one code per enabled cycle,
// looping or one-shot over a run-selected length. Define SEQ_GEN_WRITE_EN to make the table writable.
module seq_pattern_gen #(
  parameter int                     WIDTH = 2,
  parameter int                     DEPTH = 7,
  parameter logic [WIDTH*DEPTH-1:0] INIT  = 14'h369C,
  localparam int                    AW    = $clog2(DEPTH),
  localparam int                    LW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  input  logic [LW-1:0]    length,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out,
  output logic [AW-1:0]    index,
  output logic             valid,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [LW-1:0]    len_q, len_d, len_clamp;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_d, rd_data;
  logic [AW-1:0]    index_d;
  logic             valid_d, wrap_d, busy_d, last;

  function automatic logic [WIDTH-1:0] init_entry(input int i);
    return INIT[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0 || int'(l) > DEPTH)
      return LW'(DEPTH);
    return l;
  endfunction

`ifdef SEQ_GEN_WRITE_EN
  logic [WIDTH-1:0] tbl [DEPTH];

  // Registered table: a same-edge read sees the old entry, the write lands for the next read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= init_entry(i);
    end else if (wr_en && int'(wr_addr) < DEPTH) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  assign rd_data = tbl[ptr_q];
`else
  logic unused_wr;

  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign rd_data   = init_entry(int'(ptr_q));
`endif

  assign len_clamp = clamp_len(length);
  assign last      = (LW'(ptr_q) == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    mode_d  = mode_q;
    out_d   = out;
    index_d = index;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            len_d   = len_clamp;
            mode_d  = mode;
            ptr_d   = '0;
          end
        end
        RUN: begin
          // A start while running restarts the pass; nothing is emitted on that edge.
          if (start) begin
            len_d  = len_clamp;
            mode_d = mode;
            ptr_d  = '0;
          end else if (en) begin
            out_d   = rd_data;
            index_d = ptr_q;
            valid_d = 1'b1;
            if (last) begin
              wrap_d = 1'b1;
              ptr_d  = '0;
              if (mode_q)
                state_d = DONE;
            end else begin
              ptr_d = ptr_q + AW'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= LW'(DEPTH);
      mode_q  <= 1'b0;
      out     <= '0;
      index   <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      out     <= out_d;
      index   <= index_d;
      valid   <= valid_d;
      wrap    <= wrap_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: directed scenarios plus randomized stimulus against a
// count-based reference model. Honours SEQ_GEN_WRITE_EN the same way as the design.
module tb_seq_pattern_gen;

  localparam int DEPTH = 7;
  localparam int WIDTH = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, en = 1'b0, mode = 1'b0;
  logic [2:0] length = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic [1:0] out;
  logic [2:0] index;
  logic       valid, wrap, busy;

  seq_pattern_gen dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .en(en), .mode(mode),
    .length(length), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out), .index(index), .valid(valid), .wrap(wrap), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] code;
    logic [2:0] idx;
    logic       wrp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int init_vals[DEPTH] = '{0, 3, 1, 2, 2, 1, 3};
  int m_tab[DEPTH];
  bit m_run, m_done, m_oneshot, m_valid, m_wrap;
  int m_len, m_cnt, m_out, m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = init_vals[i];
    m_run = 0; m_done = 0; m_oneshot = 0; m_valid = 0; m_wrap = 0;
    m_len = DEPTH; m_cnt = 0; m_out = 0; m_idx = 0;
  endtask

  // One clock edge of the reference: the n-th code of a run is table[n mod len].
  task automatic model_edge();
    int p;
    m_valid = 0;
    m_wrap  = 0;
    if (stop) begin
      m_run = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_run     = 1;
      m_len     = (length == 0 || int'(length) > DEPTH) ? DEPTH : int'(length);
      m_oneshot = mode;
      m_cnt     = 0;
    end else if (m_run && en) begin
      p       = m_cnt % m_len;
      m_out   = m_tab[p];
      m_idx   = p;
      m_valid = 1;
      m_wrap  = (p == m_len - 1);
      m_cnt++;
      if (m_oneshot && m_cnt == m_len) begin
        m_run = 0; m_done = 1;
      end
      exp_q.push_back('{code: 2'(m_out), idx: 3'(m_idx), wrp: m_wrap});
    end
`ifdef SEQ_GEN_WRITE_EN
    if (wr_en && int'(wr_addr) < DEPTH) m_tab[wr_addr] = int'(wr_data);
`endif
  endtask

  task automatic step(input logic s, input logic st, input logic e, input logic md,
                      input logic [2:0] ln, input logic we, input logic [2:0] wa,
                      input logic [1:0] wd);
    @(negedge clock);
    start = s; stop = st; en = e; mode = md; length = ln;
    wr_en = we; wr_addr = wa; wr_data = wd;
    model_edge();
    @(posedge clock);
    #1;
    chk("cycle{valid,busy,wrap,index,out}", {valid, busy, wrap, index, out},
        {m_valid, m_run, m_wrap, 3'(m_idx), 2'(m_out)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 0, 3'd0, 2'd0);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #1;
    start = 0; stop = 0; en = 0; mode = 0; length = 0; wr_en = 0;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {out, index, valid, wrap, busy}, 8'h00);
    model_reset();
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: pops one expected code each time the DUT flags valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out=%0d index=%0d, expected no code", out, index);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard{out,index,wrap}", {out, index, wrap}, {e.code, e.idx, e.wrp});
        end
      end
    end
  end

  initial begin
    int         seq_d[DEPTH] = '{0, 3, 1, 2, 2, 1, 3};
    int         seq_w[4];
    logic [1:0] held;

    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("reset_outputs", {out, index, valid, wrap, busy}, 8'h00);
    #10 reset = 1'b1;

    // Loop mode, full length
    step(1, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    chk("start_busy", busy, 1);
    chk("start_no_code", valid, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
      chk("loop_seq", out, 32'(seq_d[i % DEPTH]));
      chk("loop_wrap", wrap, 32'(i % DEPTH == DEPTH - 1));
    end
    step(0, 1, 0, 0, 3'd0, 0, 3'd0, 2'd0);

    // One-shot, length 3
    step(1, 0, 1, 1, 3'd3, 0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    chk("oneshot_last_wrap", wrap, 1);
    chk("oneshot_busy_falls", busy, 0);
    idle(3);
    chk("oneshot_out_holds", out, 1);

    // Enable toggled 1,0,0,1, length 1 then length 5
    step(1, 0, 1, 0, 3'd1, 0, 3'd0, 2'd0);
    step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    chk("len1_wrap", {out, wrap}, 3'b001);
    step(1, 0, 1, 0, 3'd5, 0, 3'd0, 2'd0);
    step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    held = out;
    step(0, 0, 0, 0, 3'd0, 0, 3'd0, 2'd0);
    step(0, 0, 0, 0, 3'd0, 0, 3'd0, 2'd0);
    chk("en_low_hold", {valid, out}, {1'b0, held});
    step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    chk("en_resume", out, 1);

    // Stop together with start mid-run
    step(1, 1, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    chk("stop_wins_busy", busy, 0);
    idle(2);
    chk("stop_stays_idle", busy, 0);

    // Table write then length-4 loop
    step(0, 0, 0, 0, 3'd0, 1, 3'd2, 2'd0);
    step(0, 0, 0, 0, 3'd0, 1, 3'd7, 2'd3);
    step(1, 0, 1, 0, 3'd4, 0, 3'd0, 2'd0);
`ifdef SEQ_GEN_WRITE_EN
    seq_w = '{0, 3, 0, 2};
`else
    seq_w = '{0, 3, 1, 2};
`endif
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
      chk("len4_seq", out, 32'(seq_w[i % 4]));
    end

    // Asynchronous reset mid-run
    async_reset();
    step(1, 0, 1, 0, 3'd6, 0, 3'd0, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 3'd0, 0, 3'd0, 2'd0);
    async_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    step(0, 1, 0, 0, 3'd0, 0, 3'd0, 2'd0);
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
